pipe_skid_buf: RTL

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

---
 rtl/pipe_skid_buf.sv | 46 ++++
 1 files changed

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry registered skid buffer with flush; full throughput, no in-to-out combinational path
module pipe_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] skid;
    logic push, pop, ld_main_in, ld_main_skid, ld_skid;
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= EMPTY;
        else state <= state_nxt;
    always_comb begin
        state_nxt = flush ? EMPTY :
                    state == EMPTY ? (push ? ONE : EMPTY) :
                    state == ONE ? ((push && !pop) ? FULL : (!push && pop) ? EMPTY : ONE) :
                    (pop ? ONE : FULL);
    end
    always_comb begin
        out_valid = state != EMPTY;
        in_ready  = state != FULL;
        occupancy = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
    end
    // flush suppresses every load so a word pushed in the flush cycle is dropped
    assign ld_main_in   = !flush && push && (state == EMPTY || pop);
    assign ld_main_skid = !flush && state == FULL && pop;
    assign ld_skid      = !flush && state == ONE && push && !pop;
    always_ff @(posedge clk or negedge reset)
        if (!reset) out_data <= '0;
        else if (ld_main_in) out_data <= in_data;
        else if (ld_main_skid) out_data <= skid;
    always_ff @(posedge clk)
        if (ld_skid) skid <= in_data;
endmodule
